// File: rtl/rr_arbiter8_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter8_pick8.sv
// Combinational round-robin picker: the search starts just above ptr and wraps,
// done as rotate, lowest-set-bit encode, rotate back.
module rr_pick8
  import rr_arbiter8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0]   start;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   rot_idx;

  assign start = ptr + 3'd1;
  assign dbl   = {req, req} >> start;
  assign rot   = dbl[N_REQ-1:0];
  assign any   = |req;

  always_comb begin
    rot_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) rot_idx = i[IDX_W-1:0];
    end
  end

  assign idx    = rot_idx + start;
  assign winner = any ? (8'b1 << idx) : '0;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with bounded grant tenure; all outputs
// are registered, and a release hands the grant straight to the next winner.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arb_en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             hold_expired
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [7:0]       hold_reg, hold_next;
  logic [N_REQ-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             valid_reg;
  logic             expired_reg, expired_next;

  logic [IDX_W-1:0] pick_ptr;
  logic [N_REQ-1:0] pick_winner;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             owner_req;
  logic             expire;

  // While granted, search as if the owner were the pointer so it ends up lowest.
  assign pick_ptr = (state_reg == ST_GRANT) ? idx_reg : ptr_reg;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .winner (pick_winner),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign owner_req = req[idx_reg];
  assign expire    = owner_req && (hold_reg == HOLD_LAST);

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    hold_next    = hold_reg;
    grant_next   = grant_reg;
    idx_next     = idx_reg;
    expired_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (arb_en && pick_any) begin
          state_next = ST_GRANT;
          grant_next = pick_winner;
          idx_next   = pick_idx;
          hold_next  = '0;
        end
      end
      ST_GRANT: begin
        if (!owner_req || expire) begin
          ptr_next     = idx_reg;
          expired_next = expire;
          if (arb_en && pick_any) begin
            grant_next = pick_winner;
            idx_next   = pick_idx;
            hold_next  = '0;
          end else begin
            state_next = ST_IDLE;
            grant_next = '0;
            idx_next   = '0;
            hold_next  = '0;
          end
        end else begin
          hold_next = hold_reg + 8'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= 3'd7;
      hold_reg    <= '0;
      grant_reg   <= '0;
      idx_reg     <= '0;
      valid_reg   <= 1'b0;
      expired_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      hold_reg    <= hold_next;
      grant_reg   <= grant_next;
      idx_reg     <= idx_next;
      valid_reg   <= |grant_next;
      expired_reg <= expired_next;
    end
  end

  assign grant        = grant_reg;
  assign grant_idx    = idx_reg;
  assign grant_valid  = valid_reg;
  assign hold_expired = expired_reg;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 (MAX_HOLD=4): expected grants are queued as
// stimulus is driven and compared after each clock edge.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arb_en = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       hold_expired;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] g;
    logic       e;
  } exp_t;

  exp_t sb[$];

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arb_en       (arb_en),
    .req          (req),
    .grant        (grant),
    .grant_idx    (grant_idx),
    .grant_valid  (grant_valid),
    .hold_expired (hold_expired)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] enc(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (v[i]) r = i[2:0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] eg, input logic ee);
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".idx"}, 32'(grant_idx), 32'(enc(eg)));
    chk({tag, ".valid"}, 32'(grant_valid), 32'(|eg));
    chk({tag, ".expired"}, 32'(hold_expired), 32'(ee));
    chk({tag, ".onehot"}, 32'($countones(grant) <= 1), 32'd1);
    $display("%0t %s req=%h en=%0d grant=%h idx=%0d valid=%0d exp=%0d",
             $time, tag, req, arb_en, grant, grant_idx, grant_valid, hold_expired);
  endtask

  // Drive one cycle of inputs, queue the expected result, compare after the edge.
  task automatic cycle(input string tag, input logic [7:0] r, input logic en,
                       input logic [7:0] eg, input logic ee);
    exp_t x;
    req    = r;
    arb_en = en;
    sb.push_back('{tag, eg, ee});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check_all(x.tag, x.g, x.e);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    req    = '0;
    arb_en = 1'b1;
    rst_n  = 1'b0;
    #1;
    check_all(tag, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state and single-requester latency
    do_reset("rst0");
    cycle("t1_grant", 8'h01, 1'b1, 8'h01, 1'b0);
    cycle("t1_drop", 8'h00, 1'b1, 8'h00, 1'b0);

    // All requesting: rotation 0..7,0, four cycles each, no idle gap
    do_reset("rst1");
    for (int k = 0; k < 9; k++) begin
      for (int j = 0; j < 4; j++) begin
        cycle($sformatf("t2_own%0d_c%0d", k % 8, j), 8'hFF, 1'b1,
              8'(1 << (k % 8)), (k > 0) && (j == 0));
      end
    end
    cycle("t2_drop", 8'h00, 1'b1, 8'h00, 1'b0);

    // Voluntary release from owner 2: search 3..7 before 1
    do_reset("rst2");
    cycle("t3_own2", 8'h04, 1'b1, 8'h04, 1'b0);
    cycle("t3_move7", 8'h82, 1'b1, 8'h80, 1'b0);
    cycle("t3_drop", 8'h00, 1'b1, 8'h00, 1'b0);

    // Lone requester re-granted on expiry without a gap
    do_reset("rst3");
    for (int c = 1; c <= 12; c++) begin
      cycle($sformatf("t4_c%0d", c), 8'h20, 1'b1, 8'h20, (c == 5) || (c == 9));
    end
    cycle("t4_drop", 8'h00, 1'b1, 8'h00, 1'b0);

    // arb_en gating
    do_reset("rst4");
    cycle("t5_dis0", 8'h10, 1'b0, 8'h00, 1'b0);
    cycle("t5_dis1", 8'h10, 1'b0, 8'h00, 1'b0);
    cycle("t5_en", 8'h10, 1'b1, 8'h10, 1'b0);
    cycle("t5_hold", 8'h10, 1'b0, 8'h10, 1'b0);
    cycle("t5_rel", 8'h40, 1'b0, 8'h00, 1'b0);
    cycle("t5_idle", 8'h40, 1'b0, 8'h00, 1'b0);

    // Asynchronous reset mid-grant, then pointer back at 7
    do_reset("rst5");
    cycle("t6_own3", 8'h08, 1'b1, 8'h08, 1'b0);
    cycle("t6_hold", 8'h08, 1'b1, 8'h08, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("t6_async", 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle("t6_after", 8'h88, 1'b1, 8'h08, 1'b0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one downstream resource among 8 requesters, e.g. a shared bus or the display/encoder datapath.
- Each request is one bit of an 8-bit vector. The winner is reported as a one-hot grant and as a 3-bit encoded index, so the block sits directly in front of the encoder stage.
- Grants are held while the owner keeps requesting, up to a bounded tenure, then priority rotates.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 for this block, because the index is 3 bits.
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant; legal range 1..255.

Ports:
- clk, input, 1, system clock; rising edge active.
- rst_n, input, 1, asynchronous active-low reset.
- arb_en, input, 1, when 0 no new grant is issued; an existing grant still completes normally.
- req, input, 8, request vector; bit k = requester k.
- grant, output, 8, registered one-hot grant; all zeros when idle.
- grant_idx, output, 3, binary index of the granted bit; 0 when idle.
- grant_valid, output, 1, high whenever grant is non-zero.
- hold_expired, output, 1, one-cycle pulse when an owner loses the grant by tenure limit.

Behaviour:
- Reset (async assert, sync release):
  - grant=0, grant_idx=0, grant_valid=0, hold_expired=0.
  - Priority pointer ptr=7, so requester 0 has top priority first.
  - hold_cnt=0; state=IDLE.
- Priority search: start at ptr+1 mod 8 and wrap upward; the first set bit of the masked request vector wins. The search is combinational; all outputs are registered.
- State IDLE:
  - If arb_en=1 and req!=0: winner is granted on the next edge; go to GRANT with hold_cnt=0.
  - Latency: req rising at edge t gives grant visible after edge t+1.
- State GRANT (owner o):
  - Stay while req[o]=1 and hold_cnt<MAX_HOLD-1; hold_cnt increments by 1 each cycle.
  - Release when req[o]=0 (voluntary) or hold_cnt==MAX_HOLD-1 with req[o]=1 (expiry). On release, ptr<=o.
  - On the release cycle, arbitrate among req with o at lowest priority:
    - If arb_en=1 and a winner exists, grant moves to it on the same edge (no idle bubble), hold_cnt<=0.
    - Otherwise go to IDLE; grant=0 for at least one cycle.
  - On expiry, o is re-granted only if no other bit is set; this counts as a fresh tenure (hold_cnt=0). hold_expired pulses for that edge in either case.
- arb_en=0 during GRANT: the owner keeps the grant until release; on release go to IDLE regardless of other requests.
- A requester dropping req while not granted has no effect. Requests are level-sensitive and are not latched.
- The grant is always one-hot or zero; two grant bits are never high together.
- grant_idx is the encoding of grant, and grant_valid = |grant, both in the same cycle.
- Reset asserted mid-grant: all outputs clear immediately (asynchronously); ptr returns to 7.

Decomposition:
- Shared package/header holds:
  - constants N_REQ=8 and IDX_W=3;
  - state encodings ST_IDLE=1'b0 and ST_GRANT=1'b1.
- One sub-module: rr_pick8. It is combinational: inputs are the 8-bit req and the 3-bit ptr; outputs are a one-hot winner, a 3-bit index and an any flag. It is implemented as a rotate, priority encode, rotate-back.
- FSM, ptr, hold_cnt and output registers live in rr_arbiter8.

Test Plan:
- Reset then req=8'b0000_0001 -> grant=8'h01, grant_idx=0, grant_valid=1 one cycle after req; drop req -> grant=0 next cycle.
- req=8'hFF held, MAX_HOLD=4 -> owners 0,1,2,...,7,0 in order, each exactly 4 cycles; hold_expired pulses at each handover; never an idle cycle.
- Owner 2 granted, req[2] drops while req=8'b1000_0010 -> grant moves to 7 (search 3..7 before 1), grant_idx=7, no bubble.
- Only req[5]=1 held, MAX_HOLD=4 -> hold_expired every 4 cycles; grant stays 8'h20 continuously.
- arb_en=0 with req=8'h10 -> grant stays 0. Set arb_en=1 -> grant=8'h10 next cycle. Clear arb_en while held, then drop req[4] with req[6]=1 -> IDLE, grant=0.
- rst_n low mid-grant (grant=8'h08) -> grant=0, grant_idx=0 immediately, without waiting for a clock edge. After release, req=8'h88 -> grant=8'h08 (ptr=7, so the search starts at 0).
